mac_accumulator: RTL and testbench



---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_acc_add.sv | 27 ++
 rtl/mac_accumulator.sv | 85 ++++++++
 tb/tb_mac_accumulator.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - state encoding and width helpers shared by mac_accumulator and its adder
package mac_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } mac_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A counter always needs at least one bit, even when LEN=1.
  function automatic int cnt_width(input int len);
    return (clog2(len) < 1) ? 1 : clog2(len);
  endfunction

endpackage

// File: rtl/mac_acc_add.sv
// rtl/mac_acc_add.sv - ACC_W+1 bit accumulate adder with wrap or saturate select
// Saturation is selected by defining MAC_ACCUMULATOR_SATURATE_EN.
module mac_acc_add #(
  parameter int P_W   = 8,
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] next_acc,
  output logic             carry
);

  localparam int SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] sum;

  assign sum   = {1'b0, acc} + SUM_W'(p);
  assign carry = sum[ACC_W];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  // Once pinned at all ones any further add carries again, so it stays pinned.
  assign next_acc = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign next_acc = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums LEN products from arraymultiplier into one held result
// Optional MAC_ACCUMULATOR_SATURATE_EN clamps the sum at all ones instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N     = 4,
  parameter int LEN   = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [2*N-1:0]   p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int             CNT_W    = cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  mac_state_t       state;
  mac_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_accept;
  logic             take_result;
  logic [ACC_W-1:0] next_acc;
  logic             carry;

  assign accept      = p_valid && p_ready;
  assign last_accept = accept && (cnt == CNT_LAST);
  assign take_result = out_valid && out_ready;

  mac_acc_add #(
    .P_W   (2*N),
    .ACC_W (ACC_W)
  ) u_add (
    .acc      (acc),
    .p        (p),
    .next_acc (next_acc),
    .carry    (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (last_accept) state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready)   state_nxt = ST_ACCUM;
      default:                   state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    p_ready   = (state == ST_ACCUM);
    out_valid = (state == ST_HOLD);
  end

  // Clearing on consumption rearms the block so the next sequence starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= next_acc;
      ovf <= ovf | carry;
      cnt <= last_accept ? '0 : cnt + 1'b1;
    end else if (take_result) begin
      acc <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator in three configurations
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] pv;
  logic [2:0] ordy;
  logic [7:0] pd [3];
  wire  [2:0] prdy;
  wire  [2:0] oval;
  wire  [2:0] ovf;
  wire  [9:0] acc0;
  wire  [7:0] acc1;
  wire  [9:0] acc2;

  int total = 0;
  int bad   = 0;

  int     lens   [3] = '{4, 2, 1};
  int     widths [3] = '{10, 8, 10};
  int     m_cnt  [3];
  longint m_sum  [3];
  bit     m_hold [3];

  always #5 clk = ~clk;

  mac_accumulator #(.N(4), .LEN(4), .ACC_W(10)) u0 (
    .clk(clk), .rst(rst[0]), .p_valid(pv[0]), .p_ready(prdy[0]), .p(pd[0]),
    .out_valid(oval[0]), .out_ready(ordy[0]), .acc(acc0), .ovf(ovf[0])
  );

  mac_accumulator #(.N(4), .LEN(2), .ACC_W(8)) u1 (
    .clk(clk), .rst(rst[1]), .p_valid(pv[1]), .p_ready(prdy[1]), .p(pd[1]),
    .out_valid(oval[1]), .out_ready(ordy[1]), .acc(acc1), .ovf(ovf[1])
  );

  mac_accumulator #(.N(4), .LEN(1), .ACC_W(10)) u2 (
    .clk(clk), .rst(rst[2]), .p_valid(pv[2]), .p_ready(prdy[2]), .p(pd[2]),
    .out_valid(oval[2]), .out_ready(ordy[2]), .acc(acc2), .ovf(ovf[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] dut_acc(input int i);
    case (i)
      0:       return acc0;
      1:       return {2'b00, acc1};
      default: return acc2;
    endcase
  endfunction

  // Result expected from the true mathematical sum of the current sequence.
  function automatic longint exp_acc(input int i);
    longint lim;
    lim = longint'(1) << widths[i];
    if (m_sum[i] < lim) return m_sum[i];
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    return lim - 1;
`else
    return m_sum[i] % lim;
`endif
  endfunction

  task automatic model_step(input int i, input bit r, input bit v, input logic [7:0] d, input bit o);
    if (r) begin
      m_cnt[i] = 0; m_sum[i] = 0; m_hold[i] = 1'b0;
    end else if (m_hold[i]) begin
      if (o) begin
        m_cnt[i] = 0; m_sum[i] = 0; m_hold[i] = 1'b0;
      end
    end else if (v) begin
      m_sum[i] = m_sum[i] + longint'(d);
      m_cnt[i] = m_cnt[i] + 1;
      if (m_cnt[i] == lens[i]) m_hold[i] = 1'b1;
    end
  endtask

  task automatic check_inst(input int i, input string tag);
    longint lim;
    lim = longint'(1) << widths[i];
    check($sformatf("%s.u%0d.p_ready", tag, i), prdy[i], !m_hold[i]);
    check($sformatf("%s.u%0d.out_valid", tag, i), oval[i], m_hold[i]);
    check($sformatf("%s.u%0d.acc", tag, i), dut_acc(i), exp_acc(i));
    check($sformatf("%s.u%0d.ovf", tag, i), ovf[i], m_sum[i] >= lim);
  endtask

  task automatic cycle(input int i, input bit r, input bit v, input logic [7:0] d, input bit o,
                       input string tag);
    rst = '0; pv = '0; ordy = '0;
    rst[i] = r; pv[i] = v; pd[i] = d; ordy[i] = o;
    @(posedge clk);
    model_step(i, r, v, d, o);
    #1;
    check_inst(i, tag);
  endtask

  initial begin
    rst = 3'b111; pv = '0; ordy = '0;
    for (int i = 0; i < 3; i++) pd[i] = '0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, 1'b1, 1'b0, 8'd0, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) check_inst(i, "reset");

    // Back-to-back 225s give 900 with no overflow, then consume.
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 8'd225, 0, "b2b");
    check("b2b.acc900", acc0, 900);
    check("b2b.ovf", ovf[0], 0);
    cycle(0, 0, 0, 8'd0, 1, "b2b_take");
    check("b2b_take.acc0", acc0, 0);

    // Idle gaps between products must not advance the count.
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 1, 8'(k), 0, "gaps");
      cycle(0, 0, 0, 8'd99, 0, "gaps_idle");
      cycle(0, 0, 0, 8'd99, 0, "gaps_idle");
    end
    check("gaps.acc10", acc0, 10);
    cycle(0, 0, 0, 8'd0, 1, "gaps_take");

    // Backpressure while a product is offered.
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 8'd225, 0, "bp_fill");
    for (int k = 0; k < 5; k++) cycle(0, 0, 1, 8'd7, 0, "bp_hold");
    check("bp.acc900", acc0, 900);
    cycle(0, 0, 1, 8'd7, 1, "bp_release");
    cycle(0, 0, 1, 8'd7, 0, "bp_first");
    check("bp.first7", acc0, 7);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 8'd0, 0, "bp_rest");
    cycle(0, 0, 0, 8'd0, 1, "bp_take");

    // Reset discards a partial sum.
    cycle(0, 0, 1, 8'd50, 0, "rst_mid");
    cycle(0, 0, 1, 8'd50, 0, "rst_mid");
    cycle(0, 1, 1, 8'd50, 0, "rst_mid_rst");
    check("rst_mid.acc0", acc0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 8'd1, 0, "rst_ones");
    check("rst_ones.acc4", acc0, 4);
    cycle(0, 0, 0, 8'd0, 1, "rst_take");

    // Narrow accumulator overflow.
    cycle(1, 0, 1, 8'd225, 0, "ovf8");
    cycle(1, 0, 1, 8'd225, 0, "ovf8");
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    check("ovf8.acc", acc1, 255);
`else
    check("ovf8.acc", acc1, 194);
`endif
    check("ovf8.ovf", ovf[1], 1);
    cycle(1, 0, 0, 8'd0, 1, "ovf8_take");
    check("ovf8_take.ovf", ovf[1], 0);

    // LEN=1 alternates accept and hold with out_ready held high.
    cycle(2, 0, 1, 8'd13, 0, "len1");
    check("len1.acc13", acc2, 13);
    check("len1.valid", oval[2], 1);
    for (int k = 0; k < 6; k++) cycle(2, 0, 1, 8'd13, 1, "len1_alt");

    // Random traffic on every configuration.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 400; k++) begin
        cycle(i, ($urandom % 50) == 0, ($urandom % 4) != 0, 8'($urandom),
              ($urandom % 3) == 0, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
